branch_resolve: RTL and testbench
=================================

# branch_resolve

Branch-resolution stage sitting directly downstream of the 12-bit comparison-flag register. It accepts one conditional branch at a time from decode, selects one flag bit of the comparison register by a 4-bit condition code, and waits if a CMP is still in flight. On a taken branch it issues a one-cycle PC redirect and a pipeline flush, and it keeps a saturating count of taken branches.

## Interface
- PC_W, 16, width of PC and branch target
- FLUSH_CYCLES, 2, cycles `o_flush` stays high after a taken branch; legal range 1..15
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- i_br_valid  in  1  branch request from decode; held until accepted
- i_br_cond  in  4  flag select: 0..9 ALU flags, 10 never, 11 always, 12..15 reserved (treated as never)
- i_br_target  in  PC_W  absolute branch target
- i_cmp_pending  in  1  a CMP is in execute this cycle; the flag register updates at this cycle's clock edge
- i_comp_reg  in  12  comparison flag register: bit 11 always=1, bit 10 never=0, bits 9..0 ALU flags
- o_br_ready  out  1  block can accept a branch
- o_stall  out  1  decode must hold (waiting for flags or flushing)
- o_redirect_valid  out  1  one-cycle pulse: fetch must load `o_redirect_pc`
- o_redirect_pc  out  PC_W  redirect target; holds its last value
- o_flush  out  1  squash younger instructions
- o_taken_cnt  out  16  count of taken branches, saturating at 0xFFFF

## Operation
- States: IDLE, WAIT_FLAGS, FLUSH.
- Accept happens when `i_br_valid && o_br_ready`.
- `o_br_ready` = (state==IDLE) && !reset.
- `o_stall` = (state != IDLE), or an accept with `i_cmp_pending`=1.
- On accept, latch cond and target.
- **IDLE, accept with `i_cmp_pending`=0:**
  - Evaluate `taken = i_comp_reg[cond]` in the same cycle; cond ≥ 12 gives 0.
  - Taken: go to FLUSH.
  - Not taken: stay in IDLE; no redirect, no flush, no stall.
- **IDLE, accept with `i_cmp_pending`=1:** go to WAIT_FLAGS.
- **WAIT_FLAGS:**
  - While `i_cmp_pending`=1 (back-to-back CMPs), stay.
  - When it is 0, evaluate the latched cond against `i_comp_reg`.
  - Taken: go to FLUSH. Not taken: go to IDLE.
- **FLUSH:**
  - Load a down-counter with FLUSH_CYCLES.
  - `o_flush`=1 in every FLUSH cycle.
  - Go to IDLE when the count reaches 1.
- **Taken counter:** `o_taken_cnt` increments once per taken evaluation. At 0xFFFF it holds.
- **Reset values:**
  - state IDLE.
  - `o_redirect_valid` 0, `o_redirect_pc` 0, `o_flush` 0, `o_taken_cnt` 0, `o_stall` 0, `o_br_ready` 0.
- **Reset mid-operation:** a branch in WAIT_FLAGS or FLUSH is dropped. Outputs return to reset values on the next edge, and no redirect is issued afterwards.
- `i_br_valid` while `o_br_ready`=0 is ignored; upstream holds it.

## Timing
- **Evaluation cycle E:** the accept cycle, or the first WAIT_FLAGS cycle with `i_cmp_pending`=0.
- **Taken branch:** `o_redirect_valid`=1 and `o_redirect_pc`=target during cycle E+1, for exactly one cycle.
- **Flush window:** `o_flush` is high during cycles E+1 .. E+FLUSH_CYCLES.
- **Ready after taken:** `o_br_ready` returns high at cycle E+FLUSH_CYCLES+1.
- **Ready after not taken:** `o_br_ready` is high at cycle E+1. A not-taken branch accepted in IDLE costs zero stall cycles.
- **CMP wait:** a CMP pending at accept adds exactly one cycle per consecutive pending cycle before E.
- **Counter timing:** `o_taken_cnt` is updated at the E→E+1 edge, visible in E+1.

## Test plan
- **Reset release.** After reset: `o_br_ready`=1, all other outputs 0. Branch with cond=11, target 0x0040 → E+1: redirect_valid=1, pc=0x0040; flush high 2 cycles; taken_cnt=1.
- **Never/not-taken.** cond=10, then cond=3 with `i_comp_reg[3]`=0 → no redirect, no flush; `o_br_ready` stays high; taken_cnt unchanged.
- **CMP hazard.**
  - Accept cond=5, target 0x1234, with `i_cmp_pending`=1.
  - The old register has bit5=0; next cycle the register has bit5=1 and pending=0.
  - Required: redirect to 0x1234 one cycle after that; stall high throughout.
  - Repeat with pending high for 3 cycles → E delayed 3 cycles.
- **Reserved code and FLUSH_CYCLES=1.** cond=13 with `i_comp_reg`=0xFFF → not taken. With FLUSH_CYCLES=1, a taken branch gives a single flush cycle, and the next branch is accepted at E+2.
- **Reset mid-FLUSH and mid-WAIT_FLAGS.** Assert reset in either state → no redirect on later cycles, state IDLE, taken_cnt=0.
- **Saturation.** Force 65536 taken branches → `o_taken_cnt`=0xFFFF and holds after a further taken branch.

Source files
------------

// File: rtl/branch_resolve.sv
// Resolves one conditional branch at a time against the 12-bit comparison-flag register.
// Latency: taken/not-taken decided in the evaluation cycle; redirect pulse and flush start one cycle later.
// Backpressure: o_br_ready low while waiting on an in-flight CMP or flushing; decode holds i_br_valid.
module branch_resolve #(
    parameter int PC_W         = 16,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            i_br_valid,
    input  logic [3:0]      i_br_cond,
    input  logic [PC_W-1:0] i_br_target,
    input  logic            i_cmp_pending,
    input  logic [11:0]     i_comp_reg,
    output logic            o_br_ready,
    output logic            o_stall,
    output logic            o_redirect_valid,
    output logic [PC_W-1:0] o_redirect_pc,
    output logic            o_flush,
    output logic [15:0]     o_taken_cnt
);

    typedef enum logic [1:0] {
        S_IDLE       = 2'd0,
        S_WAIT_FLAGS = 2'd1,
        S_FLUSH      = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [3:0]      cond_q;
    logic [PC_W-1:0] target_q;
    logic [3:0]      flush_cnt;
    logic [15:0]     taken_cnt_q;

    logic            accept;
    logic            eval;
    logic            taken;
    logic [3:0]      cond_sel;
    logic [PC_W-1:0] target_sel;
    logic [15:0]     flags_ext;

    // Codes 12..15 land on the zero-extended upper bits, so reserved codes never take.
    assign flags_ext   = {4'b0000, i_comp_reg};
    assign o_taken_cnt = taken_cnt_q;

    // Next-state and handshake/flush outputs; in IDLE the live request is evaluated, otherwise the latched one.
    always_comb begin
        state_nxt  = state;
        o_br_ready = (state == S_IDLE) && !reset;
        accept     = i_br_valid && o_br_ready;
        o_stall    = (state != S_IDLE);
        o_flush    = (state == S_FLUSH);
        eval       = 1'b0;
        cond_sel   = cond_q;
        target_sel = target_q;
        case (state)
            S_IDLE: begin
                cond_sel   = i_br_cond;
                target_sel = i_br_target;
                if (accept) begin
                    if (i_cmp_pending) begin
                        o_stall   = 1'b1;
                        state_nxt = S_WAIT_FLAGS;
                    end else begin
                        eval = 1'b1;
                    end
                end
            end
            S_WAIT_FLAGS: begin
                if (!i_cmp_pending) begin
                    eval      = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            S_FLUSH: begin
                if (flush_cnt == 4'd1) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
        taken = eval && flags_ext[cond_sel];
        if (taken) begin
            state_nxt = S_FLUSH;
        end
    end

    // State register; reset drops any branch in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Capture the branch on accept so WAIT_FLAGS can evaluate it later.
    always_ff @(posedge clk) begin
        if (reset) begin
            cond_q   <= 4'd0;
            target_q <= '0;
        end else if (accept) begin
            cond_q   <= i_br_cond;
            target_q <= i_br_target;
        end
    end

    // One-cycle redirect pulse after a taken evaluation; the PC holds its last value.
    always_ff @(posedge clk) begin
        if (reset) begin
            o_redirect_valid <= 1'b0;
            o_redirect_pc    <= '0;
        end else begin
            o_redirect_valid <= taken;
            if (taken) begin
                o_redirect_pc <= target_sel;
            end
        end
    end

    // Flush window length: loaded on a taken evaluation, counted down while flushing.
    always_ff @(posedge clk) begin
        if (reset) begin
            flush_cnt <= 4'd0;
        end else if (taken) begin
            flush_cnt <= 4'(FLUSH_CYCLES);
        end else if (state == S_FLUSH) begin
            flush_cnt <= flush_cnt - 4'd1;
        end
    end

    // Saturating count of taken branches.
    always_ff @(posedge clk) begin
        if (reset) begin
            taken_cnt_q <= 16'd0;
        end else if (taken && (taken_cnt_q != 16'hFFFF)) begin
            taken_cnt_q <= taken_cnt_q + 16'd1;
        end
    end

endmodule

// File: tb/tb_branch_resolve.sv
// Self-checking bench for branch_resolve: main instance with a 2-cycle flush, second with a 1-cycle flush.
// Latency: redirects are checked against a queue of expected targets filled when branches are driven.
// Backpressure: requests are held while the block reports not ready.
module tb_branch_resolve;

    logic        clk = 1'b0;
    logic        reset;
    logic        v0, v1;
    logic [3:0]  cond;
    logic [15:0] target;
    logic        pending;
    logic [11:0] comp;

    logic        rdy0, stall0, rv0, fl0;
    logic [15:0] rpc0, cnt0;
    logic        rdy1, stall1, rv1, fl1;
    logic [15:0] rpc1, cnt1;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [15:0] exp_q[$];
    logic [15:0] exp_cnt  = 16'd0;

    always #5 clk = ~clk;

    branch_resolve #(.PC_W(16), .FLUSH_CYCLES(2)) dut (
        .clk(clk), .reset(reset), .i_br_valid(v0), .i_br_cond(cond), .i_br_target(target),
        .i_cmp_pending(pending), .i_comp_reg(comp), .o_br_ready(rdy0), .o_stall(stall0),
        .o_redirect_valid(rv0), .o_redirect_pc(rpc0), .o_flush(fl0), .o_taken_cnt(cnt0)
    );

    branch_resolve #(.PC_W(16), .FLUSH_CYCLES(1)) dut1 (
        .clk(clk), .reset(reset), .i_br_valid(v1), .i_br_cond(cond), .i_br_target(target),
        .i_cmp_pending(pending), .i_comp_reg(comp), .o_br_ready(rdy1), .o_stall(stall1),
        .o_redirect_valid(rv1), .o_redirect_pc(rpc1), .o_flush(fl1), .o_taken_cnt(cnt1)
    );

    // Scoreboard: every redirect pulse of the main instance must match the oldest expected target.
    always @(negedge clk) begin
        if (rv0 === 1'b1) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL sb_unexpected_redirect: got pc %h, required no redirect", rpc0);
            end else begin
                logic [15:0] e;
                e = exp_q.pop_front();
                if (rpc0 !== e) $display("FAIL sb_redirect_pc: got %h required %h", rpc0, e);
                else n_pass++;
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic bump_cnt;
        exp_cnt = (exp_cnt == 16'hFFFF) ? exp_cnt : exp_cnt + 16'd1;
    endtask

    task automatic test_reset;
        reset = 1'b1; v0 = 1'b0; v1 = 1'b0; cond = 4'd0; target = 16'd0; pending = 1'b0; comp = 12'h800;
        repeat (3) tick();
        @(negedge clk);
        n_checks++; if (rdy0 !== 1'b0) $display("FAIL rst_ready_in_reset: got %b required 0", rdy0); else n_pass++;
        n_checks++; if (stall0 !== 1'b0) $display("FAIL rst_stall: got %b required 0", stall0); else n_pass++;
        n_checks++; if (rv0 !== 1'b0) $display("FAIL rst_redirect_valid: got %b required 0", rv0); else n_pass++;
        n_checks++; if (rpc0 !== 16'h0000) $display("FAIL rst_redirect_pc: got %h required 0000", rpc0); else n_pass++;
        n_checks++; if (fl0 !== 1'b0) $display("FAIL rst_flush: got %b required 0", fl0); else n_pass++;
        n_checks++; if (cnt0 !== 16'h0000) $display("FAIL rst_taken_cnt: got %h required 0000", cnt0); else n_pass++;
        tick();
        reset = 1'b0;
        @(negedge clk);
        n_checks++; if (rdy0 !== 1'b1) $display("FAIL rst_release_ready: got %b required 1", rdy0); else n_pass++;
        n_checks++; if (stall0 !== 1'b0) $display("FAIL rst_release_stall: got %b required 0", stall0); else n_pass++;
        n_checks++; if (rdy1 !== 1'b1) $display("FAIL rst_release_ready1: got %b required 1", rdy1); else n_pass++;
        tick();
    endtask

    task automatic test_taken_always;
        comp = 12'h800; v0 = 1'b1; cond = 4'd11; target = 16'h0040;
        exp_q.push_back(16'h0040); bump_cnt();
        @(negedge clk);
        n_checks++; if (stall0 !== 1'b0) $display("FAIL always_stall_at_E: got %b required 0", stall0); else n_pass++;
        tick(); v0 = 1'b0;
        @(negedge clk);
        n_checks++; if (rv0 !== 1'b1) $display("FAIL always_redirect_E1: got %b required 1", rv0); else n_pass++;
        n_checks++; if (fl0 !== 1'b1) $display("FAIL always_flush_E1: got %b required 1", fl0); else n_pass++;
        n_checks++; if (cnt0 !== exp_cnt) $display("FAIL always_cnt: got %h required %h", cnt0, exp_cnt); else n_pass++;
        n_checks++; if (rdy0 !== 1'b0) $display("FAIL always_ready_E1: got %b required 0", rdy0); else n_pass++;
        tick();
        @(negedge clk);
        n_checks++; if (rv0 !== 1'b0) $display("FAIL always_redirect_E2: got %b required 0", rv0); else n_pass++;
        n_checks++; if (fl0 !== 1'b1) $display("FAIL always_flush_E2: got %b required 1", fl0); else n_pass++;
        tick();
        @(negedge clk);
        n_checks++; if (fl0 !== 1'b0) $display("FAIL always_flush_E3: got %b required 0", fl0); else n_pass++;
        n_checks++; if (rdy0 !== 1'b1) $display("FAIL always_ready_E3: got %b required 1", rdy0); else n_pass++;
    endtask

    task automatic test_not_taken;
        int conds[2] = '{10, 3};
        comp = 12'h800;
        for (int i = 0; i < 2; i++) begin
            v0 = 1'b1; cond = 4'(conds[i]); target = 16'h0100 + 16'(i);
            @(negedge clk);
            n_checks++; if (stall0 !== 1'b0) $display("FAIL nt_stall_c%0d: got %b required 0", conds[i], stall0); else n_pass++;
            tick(); v0 = 1'b0;
            @(negedge clk);
            n_checks++; if (rv0 !== 1'b0) $display("FAIL nt_redirect_c%0d: got %b required 0", conds[i], rv0); else n_pass++;
            n_checks++; if (fl0 !== 1'b0) $display("FAIL nt_flush_c%0d: got %b required 0", conds[i], fl0); else n_pass++;
            n_checks++; if (rdy0 !== 1'b1) $display("FAIL nt_ready_c%0d: got %b required 1", conds[i], rdy0); else n_pass++;
            n_checks++; if (cnt0 !== exp_cnt) $display("FAIL nt_cnt_c%0d: got %h required %h", conds[i], cnt0, exp_cnt); else n_pass++;
        end
    endtask

    task automatic test_taken_flags;
        int conds[3] = '{0, 3, 9};
        for (int i = 0; i < 3; i++) begin
            comp = 12'h800 | (12'h001 << conds[i]);
            v0 = 1'b1; cond = 4'(conds[i]); target = 16'h0200 + 16'(conds[i]);
            exp_q.push_back(target); bump_cnt();
            tick(); v0 = 1'b0;
            @(negedge clk);
            n_checks++; if (rv0 !== 1'b1) $display("FAIL flag_redirect_c%0d: got %b required 1", conds[i], rv0); else n_pass++;
            n_checks++; if (cnt0 !== exp_cnt) $display("FAIL flag_cnt_c%0d: got %h required %h", conds[i], cnt0, exp_cnt); else n_pass++;
            tick(); tick();
        end
        comp = 12'h800;
    endtask

    task automatic test_cmp_hazard(input int n, input bit tk);
        pending = 1'b1; comp = 12'h800; v0 = 1'b1; cond = 4'd5; target = 16'h1234;
        @(negedge clk);
        n_checks++; if (stall0 !== 1'b1) $display("FAIL hz%0d_stall_accept: got %b required 1", n, stall0); else n_pass++;
        tick(); v0 = 1'b0;
        for (int k = 1; k < n; k++) begin
            @(negedge clk);
            n_checks++; if (stall0 !== 1'b1) $display("FAIL hz%0d_stall_wait%0d: got %b required 1", n, k, stall0); else n_pass++;
            n_checks++; if (rv0 !== 1'b0) $display("FAIL hz%0d_early_redirect%0d: got %b required 0", n, k, rv0); else n_pass++;
            tick();
        end
        pending = 1'b0; comp = tk ? 12'h820 : 12'h800;
        if (tk) begin exp_q.push_back(16'h1234); bump_cnt(); end
        @(negedge clk);
        n_checks++; if (stall0 !== 1'b1) $display("FAIL hz%0d_stall_E: got %b required 1", n, stall0); else n_pass++;
        n_checks++; if (rv0 !== 1'b0) $display("FAIL hz%0d_redirect_E: got %b required 0", n, rv0); else n_pass++;
        tick(); comp = 12'h800;
        @(negedge clk);
        n_checks++; if (rv0 !== tk) $display("FAIL hz%0d_redirect_E1: got %b required %b", n, rv0, tk); else n_pass++;
        n_checks++; if (stall0 !== tk) $display("FAIL hz%0d_stall_E1: got %b required %b", n, stall0, tk); else n_pass++;
        n_checks++; if (rdy0 !== !tk) $display("FAIL hz%0d_ready_E1: got %b required %b", n, rdy0, !tk); else n_pass++;
        n_checks++; if (cnt0 !== exp_cnt) $display("FAIL hz%0d_cnt: got %h required %h", n, cnt0, exp_cnt); else n_pass++;
        if (tk) begin
            tick(); tick();
            @(negedge clk);
            n_checks++; if (rdy0 !== 1'b1) $display("FAIL hz%0d_ready_E3: got %b required 1", n, rdy0); else n_pass++;
        end
    endtask

    task automatic test_reserved;
        int conds[3] = '{12, 13, 15};
        comp = 12'hFFF;
        for (int i = 0; i < 3; i++) begin
            v0 = 1'b1; cond = 4'(conds[i]); target = 16'h0300;
            tick(); v0 = 1'b0;
            @(negedge clk);
            n_checks++; if (rv0 !== 1'b0) $display("FAIL rsv_redirect_c%0d: got %b required 0", conds[i], rv0); else n_pass++;
            n_checks++; if (fl0 !== 1'b0) $display("FAIL rsv_flush_c%0d: got %b required 0", conds[i], fl0); else n_pass++;
            n_checks++; if (cnt0 !== exp_cnt) $display("FAIL rsv_cnt_c%0d: got %h required %h", conds[i], cnt0, exp_cnt); else n_pass++;
        end
        comp = 12'h800;
    endtask

    task automatic test_back_to_back;
        comp = 12'h800; v0 = 1'b1; cond = 4'd11; target = 16'h0A00;
        exp_q.push_back(16'h0A00); bump_cnt();
        tick(); target = 16'h0B00;
        @(negedge clk);
        n_checks++; if (rdy0 !== 1'b0) $display("FAIL b2b_ready_E1: got %b required 0", rdy0); else n_pass++;
        tick();
        @(negedge clk);
        n_checks++; if (rdy0 !== 1'b0) $display("FAIL b2b_ready_E2: got %b required 0", rdy0); else n_pass++;
        tick();
        exp_q.push_back(16'h0B00); bump_cnt();
        @(negedge clk);
        n_checks++; if (rdy0 !== 1'b1) $display("FAIL b2b_ready_E3: got %b required 1", rdy0); else n_pass++;
        tick(); v0 = 1'b0;
        @(negedge clk);
        n_checks++; if (rv0 !== 1'b1) $display("FAIL b2b_second_redirect: got %b required 1", rv0); else n_pass++;
        n_checks++; if (cnt0 !== exp_cnt) $display("FAIL b2b_cnt: got %h required %h", cnt0, exp_cnt); else n_pass++;
        tick(); tick();
    endtask

    task automatic test_flush1;
        comp = 12'hFFF; v1 = 1'b1; cond = 4'd11; target = 16'h00A0;
        @(negedge clk);
        n_checks++; if (rdy1 !== 1'b1) $display("FAIL f1_ready_E: got %b required 1", rdy1); else n_pass++;
        tick(); cond = 4'd0; target = 16'h00B0;
        @(negedge clk);
        n_checks++; if (rv1 !== 1'b1) $display("FAIL f1_redirect_E1: got %b required 1", rv1); else n_pass++;
        n_checks++; if (rpc1 !== 16'h00A0) $display("FAIL f1_pc_E1: got %h required 00a0", rpc1); else n_pass++;
        n_checks++; if (fl1 !== 1'b1) $display("FAIL f1_flush_E1: got %b required 1", fl1); else n_pass++;
        n_checks++; if (rdy1 !== 1'b0) $display("FAIL f1_ready_E1: got %b required 0", rdy1); else n_pass++;
        tick();
        @(negedge clk);
        n_checks++; if (rdy1 !== 1'b1) $display("FAIL f1_ready_E2: got %b required 1", rdy1); else n_pass++;
        n_checks++; if (fl1 !== 1'b0) $display("FAIL f1_flush_E2: got %b required 0", fl1); else n_pass++;
        tick(); v1 = 1'b0;
        @(negedge clk);
        n_checks++; if (rv1 !== 1'b1) $display("FAIL f1_redirect2: got %b required 1", rv1); else n_pass++;
        n_checks++; if (rpc1 !== 16'h00B0) $display("FAIL f1_pc2: got %h required 00b0", rpc1); else n_pass++;
        n_checks++; if (cnt1 !== 16'd2) $display("FAIL f1_cnt: got %h required 0002", cnt1); else n_pass++;
        tick();
        comp = 12'h800;
    endtask

    task automatic test_reset_mid;
        comp = 12'h800; v0 = 1'b1; cond = 4'd11; target = 16'h0777;
        exp_q.push_back(16'h0777);
        tick(); v0 = 1'b0;
        @(negedge clk);
        n_checks++; if (fl0 !== 1'b1) $display("FAIL rmf_in_flush: got %b required 1", fl0); else n_pass++;
        reset = 1'b1;
        tick(); reset = 1'b0; exp_cnt = 16'd0;
        @(negedge clk);
        n_checks++; if (fl0 !== 1'b0) $display("FAIL rmf_flush: got %b required 0", fl0); else n_pass++;
        n_checks++; if (cnt0 !== 16'd0) $display("FAIL rmf_cnt: got %h required 0000", cnt0); else n_pass++;
        n_checks++; if (rdy0 !== 1'b1) $display("FAIL rmf_ready: got %b required 1", rdy0); else n_pass++;
        repeat (3) tick();
        pending = 1'b1; v0 = 1'b1; cond = 4'd11; target = 16'h0999;
        tick(); v0 = 1'b0;
        @(negedge clk);
        n_checks++; if (stall0 !== 1'b1) $display("FAIL rmw_in_wait: got %b required 1", stall0); else n_pass++;
        reset = 1'b1; pending = 1'b0;
        tick(); reset = 1'b0;
        @(negedge clk);
        n_checks++; if (rv0 !== 1'b0) $display("FAIL rmw_redirect: got %b required 0", rv0); else n_pass++;
        n_checks++; if (stall0 !== 1'b0) $display("FAIL rmw_stall: got %b required 0", stall0); else n_pass++;
        n_checks++; if (fl0 !== 1'b0) $display("FAIL rmw_flush: got %b required 0", fl0); else n_pass++;
        n_checks++; if (cnt0 !== 16'd0) $display("FAIL rmw_cnt: got %h required 0000", cnt0); else n_pass++;
        n_checks++; if (rdy0 !== 1'b1) $display("FAIL rmw_ready: got %b required 1", rdy0); else n_pass++;
        repeat (3) tick();
    endtask

    task automatic test_saturation;
        @(negedge clk);
        force dut.taken_cnt_q = 16'hFFFD;
        #1;
        release dut.taken_cnt_q;
        exp_cnt = 16'hFFFD;
        tick();
        comp = 12'h800;
        for (int i = 0; i < 3; i++) begin
            v0 = 1'b1; cond = 4'd11; target = 16'h0F00 + 16'(i);
            exp_q.push_back(target); bump_cnt();
            tick(); v0 = 1'b0;
            @(negedge clk);
            n_checks++; if (cnt0 !== exp_cnt) $display("FAIL sat_cnt_%0d: got %h required %h", i, cnt0, exp_cnt); else n_pass++;
            tick(); tick();
        end
    endtask

    initial begin
        test_reset();
        test_taken_always();
        test_not_taken();
        test_taken_flags();
        test_cmp_hazard(1, 1'b1);
        test_cmp_hazard(3, 1'b1);
        test_cmp_hazard(1, 1'b0);
        test_reserved();
        test_back_to_back();
        test_flush1();
        test_reset_mid();
        test_saturation();
        tick();
        n_checks++;
        if (exp_q.size() != 0) $display("FAIL sb_missing_redirects: got %0d pending, required 0", exp_q.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
